// File: rtl/pong_pkg.sv
// Shared types for the Pong game controller: game states and paddle command encodings.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        SCORED = 3'd3,
        OVER   = 3'd4
    } game_state_t;

    localparam logic [1:0] DY_NONE = 2'b00;
    localparam logic [1:0] DY_UP   = 2'b01;
    localparam logic [1:0] DY_DOWN = 2'b10;

    // Opposing buttons held together cancel out rather than fighting each other.
    function automatic logic [1:0] btn_dy(input logic up, input logic dn);
        if (up && !dn)
            return DY_UP;
        else if (dn && !up)
            return DY_DOWN;
        else
            return DY_NONE;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_move_tick_gen.sv
// Free-running divider producing a one-clock move tick every TICK_DIV clocks.
module move_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: game FSM, scores, serve direction and rate-limited paddle commands.
// Define AI_PADDLE_EN to drive the right paddle from ball_y/paddle_r_y instead of btn_r_*.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BIT_WIDTH    = 10,
    parameter int TICK_DIV     = 833333,
    parameter int SERVE_TICKS  = 60,
    parameter int SCORED_TICKS = 90,
    parameter int SCORE_WIDTH  = 4,
    parameter int WIN_SCORE    = 7,
    parameter int AI_DEADBAND  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   btn_l_up,
    input  logic                   btn_l_dn,
    input  logic                   btn_r_up,
    input  logic                   btn_r_dn,
    input  logic                   miss_left,
    input  logic                   miss_right,
    input  logic [BIT_WIDTH-1:0]   ball_y,
    input  logic [BIT_WIDTH-1:0]   paddle_r_y,
    output logic                   paddle_rst,
    output logic                   pause,
    output logic [1:0]             dy_l,
    output logic [1:0]             dy_r,
    output logic                   serve_dir,
    output logic [SCORE_WIDTH-1:0] score_l,
    output logic [SCORE_WIDTH-1:0] score_r,
    output logic                   winner,
    output game_state_t            state
);

    localparam int PHASE_MAX = (SERVE_TICKS > SCORED_TICKS) ? SERVE_TICKS : SCORED_TICKS;
    localparam int PW = $clog2(PHASE_MAX + 1);
    localparam logic [PW-1:0] SERVE_LAST  = PW'(SERVE_TICKS - 1);
    localparam logic [PW-1:0] SCORED_LAST = PW'(SCORED_TICKS - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN = SCORE_WIDTH'(WIN_SCORE);

    logic          move_tick;
    logic [PW-1:0] phase;
    logic [1:0]    r_cmd;

    move_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(move_tick)
    );

`ifdef AI_PADDLE_EN
    // One extra bit keeps the deadband sums from wrapping near the screen edges.
    localparam logic [BIT_WIDTH:0] DEADBAND = (BIT_WIDTH + 1)'(AI_DEADBAND);
    logic [BIT_WIDTH:0] ball_ext;
    logic [BIT_WIDTH:0] pad_ext;
    logic               unused_btn_r;

    assign ball_ext     = {1'b0, ball_y};
    assign pad_ext      = {1'b0, paddle_r_y};
    assign r_cmd        = (ball_ext > pad_ext + DEADBAND) ? DY_UP   :
                          (ball_ext + DEADBAND < pad_ext) ? DY_DOWN : DY_NONE;
    assign unused_btn_r = btn_r_up ^ btn_r_dn;
`else
    logic unused_ai;

    assign r_cmd     = btn_dy(btn_r_up, btn_r_dn);
    assign unused_ai = (^{ball_y, paddle_r_y}) ^ (AI_DEADBAND < 0);
`endif

    // Outputs are updated on the transition edge so they always describe the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            paddle_rst <= 1'b1;
            pause      <= 1'b1;
            dy_l       <= DY_NONE;
            dy_r       <= DY_NONE;
            serve_dir  <= 1'b0;
            score_l    <= '0;
            score_r    <= '0;
            winner     <= 1'b0;
            phase      <= '0;
        end else begin
            dy_l <= DY_NONE;
            dy_r <= DY_NONE;
            case (state)
                IDLE: begin
                    paddle_rst <= 1'b1;
                    pause      <= 1'b1;
                    if (start) begin
                        state      <= SERVE;
                        paddle_rst <= 1'b0;
                        score_l    <= '0;
                        score_r    <= '0;
                        serve_dir  <= 1'b0;
                        phase      <= '0;
                    end
                end
                SERVE: begin
                    if (move_tick) begin
                        if (phase == SERVE_LAST) begin
                            state <= PLAY;
                            pause <= 1'b0;
                            phase <= '0;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    // A simultaneous double miss is a dead ball: replay without scoring.
                    if (miss_left || miss_right) begin
                        state      <= SCORED;
                        pause      <= 1'b1;
                        paddle_rst <= 1'b1;
                        phase      <= '0;
                        if (miss_left && !miss_right) begin
                            serve_dir <= 1'b0;
                            if (score_r != WIN)
                                score_r <= score_r + 1'b1;
                        end else if (miss_right && !miss_left) begin
                            serve_dir <= 1'b1;
                            if (score_l != WIN)
                                score_l <= score_l + 1'b1;
                        end
                    end else if (move_tick) begin
                        dy_l <= btn_dy(btn_l_up, btn_l_dn);
                        dy_r <= r_cmd;
                    end
                end
                SCORED: begin
                    if (move_tick) begin
                        if (phase == SCORED_LAST) begin
                            phase      <= '0;
                            paddle_rst <= 1'b0;
                            if (score_l == WIN || score_r == WIN) begin
                                state  <= OVER;
                                winner <= (score_r == WIN);
                            end else begin
                                state <= SERVE;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (start) begin
                        state     <= SERVE;
                        score_l   <= '0;
                        score_r   <= '0;
                        serve_dir <= 1'b0;
                        phase     <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    paddle_rst <= 1'b1;
                    pause      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl with TICK_DIV=4, SERVE_TICKS=2, SCORED_TICKS=3, WIN_SCORE=3.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    logic       clk, rst, start;
    logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
    logic       miss_left, miss_right;
    logic [9:0] ball_y, paddle_r_y;
    logic       paddle_rst, pause, serve_dir, winner;
    logic [1:0] dy_l, dy_r;
    logic [3:0] score_l, score_r;
    game_state_t state;

    typedef struct packed {
        logic [2:0] st;
        logic       prst;
        logic       pse;
        logic [1:0] dl;
        logic [1:0] dr;
        logic       dir;
        logic [3:0] sl;
        logic [3:0] sr;
    } obs_t;

`ifdef AI_PADDLE_EN
    localparam logic [1:0] R_HOLD_DY = 2'b00;
`else
    localparam logic [1:0] R_HOLD_DY = 2'b10;
`endif

    obs_t exp_q[$];
    obs_t got, want;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc;

    pong_game_ctrl #(
        .BIT_WIDTH(10), .TICK_DIV(4), .SERVE_TICKS(2), .SCORED_TICKS(3),
        .SCORE_WIDTH(4), .WIN_SCORE(3), .AI_DEADBAND(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
        .miss_left(miss_left), .miss_right(miss_right),
        .ball_y(ball_y), .paddle_r_y(paddle_r_y),
        .paddle_rst(paddle_rst), .pause(pause), .dy_l(dy_l), .dy_r(dy_r),
        .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
        .winner(winner), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent copy of the tick phase: clocks seen since reset release, modulo TICK_DIV.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic obs_t mk(input game_state_t st, input logic prst, input logic pse,
                                input logic [1:0] dl, input logic [1:0] dr, input logic dir,
                                input logic [3:0] sl, input logic [3:0] sr);
        return {st, prst, pse, dl, dr, dir, sl, sr};
    endfunction

    function automatic obs_t observe();
        return {state, paddle_rst, pause, dy_l, dy_r, serve_dir, score_l, score_r};
    endfunction

    // Returns at a negedge where the next rising edge carries a move tick.
    task automatic align();
        for (int i = 0; i < 4 && (cyc % 4) != 3; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
        miss_left = 1'b0; miss_right = 1'b0; ball_y = '0; paddle_r_y = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(IDLE, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0));
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front(); got = observe(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL reset_idle[%0d]: got %h want %h", k, got, want);
            end
        end
        compared++;
        if (winner !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_winner: got %b want 0", winner);
        end
    endtask

    task automatic test_serve_play();
        logic [1:0] dl, dr;
        int p;
        align();
        for (int k = 1; k <= 21; k++) begin
            start = (k == 1); btn_l_up = 1'b1; btn_r_dn = 1'b1; btn_l_dn = (k >= 18);
            if (k <= 8) begin
                exp_q.push_back(mk(SERVE, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0));
            end else begin
                p  = k - 8;
                dl = (p % 4 == 1 && p > 1) ? ((p == 13) ? 2'b00 : 2'b01) : 2'b00;
                dr = (p % 4 == 1 && p > 1) ? R_HOLD_DY : 2'b00;
                exp_q.push_back(mk(PLAY, 1'b0, 1'b0, dl, dr, 1'b0, 4'd0, 4'd0));
            end
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front(); got = observe(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL serve_play[%0d]: got %h want %h", k, got, want);
            end
        end
        btn_l_dn = 1'b0;
    endtask

    task automatic test_point_right();
        align();
        for (int k = 1; k <= 21; k++) begin
            miss_right = (k == 1); miss_left = (k == 15);
            if (k <= 12)      exp_q.push_back(mk(SCORED, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 4'd1, 4'd0));
            else if (k <= 20) exp_q.push_back(mk(SERVE, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 4'd1, 4'd0));
            else              exp_q.push_back(mk(PLAY, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'd1, 4'd0));
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front(); got = observe(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL point_right[%0d]: got %h want %h", k, got, want);
            end
        end
        miss_left = 1'b0;
    endtask

    task automatic test_both_miss();
        align();
        for (int k = 1; k <= 21; k++) begin
            miss_right = (k == 1); miss_left = (k == 1);
            if (k <= 12)      exp_q.push_back(mk(SCORED, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 4'd1, 4'd0));
            else if (k <= 20) exp_q.push_back(mk(SERVE, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 4'd1, 4'd0));
            else              exp_q.push_back(mk(PLAY, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'd1, 4'd0));
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front(); got = observe(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL both_miss[%0d]: got %h want %h", k, got, want);
            end
        end
    endtask

    task automatic test_win();
        for (int pt = 1; pt <= 3; pt++) begin
            align();
            for (int k = 1; k <= ((pt < 3) ? 21 : 13); k++) begin
                miss_left = (k == 1);
                if (k <= 12)
                    exp_q.push_back(mk(SCORED, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 4'd1, 4'(pt)));
                else if (pt == 3)
                    exp_q.push_back(mk(OVER, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'd1, 4'd3));
                else if (k <= 20)
                    exp_q.push_back(mk(SERVE, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'd1, 4'(pt)));
                else
                    exp_q.push_back(mk(PLAY, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 4'(pt)));
                @(posedge clk); @(negedge clk);
                want = exp_q.pop_front(); got = observe(); compared++;
                if (got !== want) begin
                    mismatched++;
                    $display("[TB] FAIL win_pt%0d[%0d]: got %h want %h", pt, k, got, want);
                end
            end
        end
        compared++;
        if (winner !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL win_winner: got %b want 1", winner);
        end
        align();
        for (int k = 1; k <= 9; k++) begin
            start = (k == 1);
            if (k <= 8) exp_q.push_back(mk(SERVE, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0));
            else        exp_q.push_back(mk(PLAY, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0));
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front(); got = observe(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL restart[%0d]: got %h want %h", k, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(mk(IDLE, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0));
        want = exp_q.pop_front(); got = observe(); compared++;
        if (got !== want || winner !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid: got %h/w%b want %h/w0", got, winner, want);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(mk(IDLE, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0));
        @(posedge clk); @(negedge clk);
        want = exp_q.pop_front(); got = observe(); compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_idle: got %h want %h", got, want);
        end
    endtask

`ifdef AI_PADDLE_EN
    task automatic test_ai();
        logic [1:0] dl, dr;
        int p;
        ball_y = 10'd200; paddle_r_y = 10'd100; btn_r_dn = 1'b1; btn_l_up = 1'b1;
        align();
        for (int k = 1; k <= 21; k++) begin
            start = (k == 1);
            if (k >= 18) ball_y = 10'd102;
            if (k <= 8) begin
                exp_q.push_back(mk(SERVE, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0));
            end else begin
                p  = k - 8;
                dl = (p % 4 == 1 && p > 1) ? 2'b01 : 2'b00;
                dr = (p % 4 == 1 && p > 1 && p < 13) ? 2'b01 : 2'b00;
                exp_q.push_back(mk(PLAY, 1'b0, 1'b0, dl, dr, 1'b0, 4'd0, 4'd0));
            end
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front(); got = observe(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL ai[%0d]: got %h want %h", k, got, want);
            end
        end
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_serve_play();
        test_point_right();
        test_both_miss();
        test_win();
        test_reset_mid();
`ifdef AI_PADDLE_EN
        test_ai();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
